// File: rtl/regfile_mp.sv
// Parameterised two-write / two-read register file with a post-reset clear sweep and a ready flag.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [AWIDTH-1:0] wa0,
  input  logic [DWIDTH-1:0] wd0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] wa1,
  input  logic [DWIDTH-1:0] wd1,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2,
  output logic              ready
);

  localparam int DEPTH    = 2 ** AWIDTH;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic clr_we;
  logic wr_en0;
  logic wr_en1;

  function automatic logic is_zero_reg(input logic [AWIDTH-1:0] addr);
    return HAS_ZERO && (addr == '0);
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    wr_en0    = 1'b0;
    wr_en1    = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we    = 1'b1;
      clr_cnt_d = clr_cnt_q + AWIDTH'(1);
      if (clr_cnt_q == AWIDTH'(DEPTH - 1)) state_d = ST_READY;
    end else begin
      wr_en0 = we0 && !is_zero_reg(wa0);
      wr_en1 = we1 && !is_zero_reg(wa1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: the array has no reset branch so it maps onto plain storage; the clear sweep zeroes it.
  // When both ports hit one address the later assignment (port 1) wins.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) mem_q[clr_cnt_q] <= '0;
      if (wr_en0) mem_q[wa0]       <= wd0;
      if (wr_en1) mem_q[wa1]       <= wd1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (state_q == ST_READY) begin
      if (!is_zero_reg(ra1)) rd1 = mem_q[ra1];
      if (!is_zero_reg(ra2)) rd2 = mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en0 && (wa0 == ra1)) rd1 = wd0;
      if (wr_en0 && (wa0 == ra2)) rd2 = wd0;
      if (wr_en1 && (wa1 == ra1)) rd1 = wd1;
      if (wr_en1 && (wa1 == ra2)) rd2 = wd1;
`endif
    end
  end

  assign ready = (state_q == ST_READY);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed clear/reset/write cases plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst_n;
  logic          we0, we1;
  logic [AW-1:0] wa0, wa1, ra1, ra2;
  logic [DW-1:0] wd0, wd1;
  logic [DW-1:0] rd1, rd2;
  logic          ready;

  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we0   (we0),
    .wa0   (wa0),
    .wd0   (wd0),
    .we1   (we1),
    .wa1   (wa1),
    .wd1   (wd1),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: contents, ready flag and number of clear edges since the last reset.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_ready;
  int            clear_edges;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] addr);
    if (!ref_ready) return '0;
    if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && wa1 == addr) return wd1;
    if (we0 && wa0 == addr) return wd0;
`endif
    return ref_mem[addr];
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      ref_ready   = 1'b0;
      clear_edges = 0;
    end else if (!ref_ready) begin
      ref_mem[clear_edges] = '0;
      clear_edges++;
      if (clear_edges == DEPTH) ref_ready = 1'b1;
    end else begin
      if (we0 && wa0 != 0) ref_mem[wa0] = wd0;
      if (we1 && wa1 != 0) ref_mem[wa1] = wd1;
    end
  endtask

  task automatic check_outputs(input string tag);
    #1;
    check({tag, "_rd1"}, rd1, exp_rd(ra1));
    check({tag, "_rd2"}, rd2, exp_rd(ra2));
    check({tag, "_ready"}, {31'd0, ready}, {31'd0, ref_ready});
  endtask

  initial begin
    logic [DW-1:0] bypass_exp;
    rst_n = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra1 = 5'd3; ra2 = 5'd17;
    ref_ready = 1'b0;
    clear_edges = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;

    // Reset held for three edges.
    repeat (3) tick();
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd1", rd1, 32'd0);
    check("reset_rd2", rd2, 32'd0);

    // Partial clear, then reset again on the 10th edge; writes attempted throughout.
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h5A5A5A5A;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'hA5A5A5A5;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_outputs("partial_clear");
    end
    rst_n = 1'b0;
    tick();
    check_outputs("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("clear_not_ready", {31'd0, ready}, 32'd0);
      tick();
    end
    we0 = 1'b0; we1 = 1'b0;
    #1;
    check("clear_done_ready", {31'd0, ready}, 32'd1);

    // Every entry reads zero after the sweep, including those targeted during clear.
    for (int a = 0; a < DEPTH; a++) begin
      ra1 = AW'(a);
      ra2 = AW'(DEPTH - 1 - a);
      #1;
      check("cleared_rd1", rd1, 32'd0);
      check("cleared_rd2", rd2, 32'd0);
    end

    // Both ports to the same address: port 1 wins.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22222222;
    tick();
    we0 = 1'b0; we1 = 1'b0; ra1 = 5'd5;
    #1;
    check("same_addr_priority", rd1, 32'h22222222);

    // Both ports to distinct addresses.
    we0 = 1'b1; wa0 = 5'd3;  wd0 = 32'hDEADBEEF;
    we1 = 1'b1; wa1 = 5'd31; wd1 = 32'h0000CAFE;
    tick();
    we0 = 1'b0; we1 = 1'b0; ra1 = 5'd3; ra2 = 5'd31;
    #1;
    check("distinct_rd1", rd1, 32'hDEADBEEF);
    check("distinct_rd2", rd2, 32'h0000CAFE);

    // Writes to entry 0 are dropped and never forwarded.
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra1 = 5'd0;
    #1;
    check("zero_reg_before", rd1, 32'd0);
    tick();
    we1 = 1'b0;
    #1;
    check("zero_reg_after", rd1, 32'd0);

    // Same-cycle read of a write in flight.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hABCD0123; ra2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'hABCD0123;
`else
    bypass_exp = 32'd0;
`endif
    #1;
    check("bypass_same_cycle", rd2, bypass_exp);
    tick();
    we0 = 1'b0;
    #1;
    check("bypass_next_cycle", rd2, 32'hABCD0123);

    // Randomized traffic with biased address collisions.
    for (int i = 0; i < 300; i++) begin
      we0 = 1'($urandom_range(1));
      we1 = 1'($urandom_range(1));
      wa0 = AW'($urandom_range(DEPTH - 1));
      wa1 = ($urandom_range(3) == 0) ? wa0 : AW'($urandom_range(DEPTH - 1));
      wd0 = $urandom;
      wd1 = $urandom;
      ra1 = ($urandom_range(2) == 0) ? wa0 : AW'($urandom_range(DEPTH - 1));
      ra2 = ($urandom_range(2) == 0) ? wa1 : AW'($urandom_range(DEPTH - 1));
      check_outputs("random");
      tick();
    end

    // Reset from READY drops back into the clear phase.
    we0 = 1'b0; we1 = 1'b0; ra1 = 5'd3; ra2 = 5'd31;
    rst_n = 1'b0;
    tick();
    #1;
    check("rereset_ready", {31'd0, ready}, 32'd0);
    check("rereset_rd1", rd1, 32'd0);
    check_outputs("rereset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
